// File: rtl/vga_pkg.sv
// Shared definitions for the TinyVGA output stage: fade FSM states, colour
// slice positions inside the 6-bit RGB word and the uo_out pin order.
package vga_pkg;

  typedef enum logic [1:0] {
    FADE_IN    = 2'd0,
    STEADY     = 2'd1,
    FADE_OUT   = 2'd2,
    HOLD_BLACK = 2'd3
  } fade_state_t;

  localparam int R_HI = 5;
  localparam int R_LO = 4;
  localparam int G_HI = 3;
  localparam int G_LO = 2;
  localparam int B_HI = 1;
  localparam int B_LO = 0;

  // Pipeline word layout: {hsync, vsync, active, rgb[5:0]}
  localparam int PIPE_W   = 9;
  localparam int PIPE_HS  = 8;
  localparam int PIPE_VS  = 7;
  localparam int PIPE_ACT = 6;

  localparam int UO_HSYNC = 7;
  localparam int UO_B0    = 6;
  localparam int UO_G0    = 5;
  localparam int UO_R0    = 4;
  localparam int UO_VSYNC = 3;
  localparam int UO_B1    = 2;
  localparam int UO_G1    = 1;
  localparam int UO_R1    = 0;

  localparam logic [1:0] MAX_LEVEL = 2'd3;

  function automatic logic is_fading(input fade_state_t s);
    return (s == FADE_IN) || (s == FADE_OUT);
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Width x depth register chain with asynchronous clear; depth 0 is a wire.
module vga_delay_line #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign dout = din;
    end else begin : g_chain
      logic [WIDTH-1:0] stage_q [DEPTH];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else begin
          stage_q[0] <= din;
          for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
      end

      assign dout = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_fade_output_stage.sv
// TinyVGA output stage: equal-delay sync/colour pipeline, active-area blanking
// and a frame-synchronous brightness fade driven by blank_req.
module vga_fade_output_stage
  import vga_pkg::*;
#(
  parameter int PIPE_STAGES = 2,
  parameter int FADE_FRAMES = 4,
  parameter bit SYNC_INV    = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       in_hsync,
  input  logic       in_vsync,
  input  logic       in_active,
  input  logic [5:0] in_rgb,
  input  logic       blank_req,
  output logic [7:0] uo_out,
  output logic [1:0] level,
  output logic       fade_busy,
  output logic       frame_tick
);

  localparam logic [7:0] CNT_LAST = 8'(FADE_FRAMES - 1);

  fade_state_t state;
  logic [7:0]  frame_cnt;
  logic        vs_prev;
  logic        vs_rise;

  logic [PIPE_W-1:0] pipe_p0;
  logic [PIPE_W-1:0] pipe_pd;
  logic [1:0]        r_s, g_s, b_s;
  logic [7:0]        uo_next;

  function automatic logic [1:0] scale_chan(input logic [1:0] c, input logic [1:0] lvl);
    return (c > lvl) ? lvl : c;
  endfunction

  function automatic logic [1:0] level_inc(input logic [1:0] lvl);
    return (lvl == MAX_LEVEL) ? lvl : lvl + 2'd1;
  endfunction

  function automatic logic [1:0] level_dec(input logic [1:0] lvl);
    return (lvl == 2'd0) ? lvl : lvl - 2'd1;
  endfunction

  // Stage p0 -> stages 1..PIPE_STAGES-1
  assign pipe_p0 = {in_hsync, in_vsync, in_active, in_rgb};

  vga_delay_line #(
    .WIDTH(PIPE_W),
    .DEPTH(PIPE_STAGES - 1)
  ) u_delay (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (pipe_p0),
    .dout (pipe_pd)
  );

  // Final stage: blank, scale and pack into the pin order
  always_comb begin
    r_s = '0;
    g_s = '0;
    b_s = '0;
    if (pipe_pd[PIPE_ACT]) begin
      r_s = scale_chan(pipe_pd[R_HI:R_LO], level);
      g_s = scale_chan(pipe_pd[G_HI:G_LO], level);
      b_s = scale_chan(pipe_pd[B_HI:B_LO], level);
    end
    uo_next           = '0;
    uo_next[UO_HSYNC] = pipe_pd[PIPE_HS] ^ SYNC_INV;
    uo_next[UO_VSYNC] = pipe_pd[PIPE_VS] ^ SYNC_INV;
    uo_next[UO_R1]    = r_s[1];
    uo_next[UO_R0]    = r_s[0];
    uo_next[UO_G1]    = g_s[1];
    uo_next[UO_G0]    = g_s[0];
    uo_next[UO_B1]    = b_s[1];
    uo_next[UO_B0]    = b_s[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) uo_out <= '0;
    else        uo_out <= uo_next;
  end

  // Frame edge detect runs regardless of ena so frame_tick keeps pulsing
  assign vs_rise = in_vsync & ~vs_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_prev    <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      vs_prev    <= in_vsync;
      frame_tick <= vs_rise;
    end
  end

  // Fade FSM: moves on the same edge that raises frame_tick, so level is
  // stable across a whole frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FADE_IN;
      level     <= 2'd0;
      frame_cnt <= '0;
    end else if (vs_rise && ena) begin
      unique case (state)
        FADE_IN: begin
          if (blank_req) begin
            state     <= FADE_OUT;
            frame_cnt <= '0;
          end else if (frame_cnt == CNT_LAST) begin
            frame_cnt <= '0;
            level     <= level_inc(level);
            if (level_inc(level) == MAX_LEVEL) state <= STEADY;
          end else begin
            frame_cnt <= frame_cnt + 8'd1;
          end
        end
        STEADY: begin
          level     <= MAX_LEVEL;
          frame_cnt <= '0;
          if (blank_req) state <= FADE_OUT;
        end
        FADE_OUT: begin
          if (!blank_req) begin
            state     <= FADE_IN;
            frame_cnt <= '0;
          end else if (frame_cnt == CNT_LAST) begin
            frame_cnt <= '0;
            level     <= level_dec(level);
            if (level_dec(level) == 2'd0) state <= HOLD_BLACK;
          end else begin
            frame_cnt <= frame_cnt + 8'd1;
          end
        end
        HOLD_BLACK: begin
          level     <= 2'd0;
          frame_cnt <= '0;
          if (!blank_req) state <= FADE_IN;
        end
        default: state <= FADE_IN;
      endcase
    end
  end

  assign fade_busy = is_fading(state);

endmodule

// File: tb/tb_vga_fade_output_stage.sv
// Bench for vga_fade_output_stage: directed scenarios plus randomized frames
// checked against a level/direction behavioural model.
module tb_vga_fade_output_stage;

  localparam int P  = 2;
  localparam int FF = 4;
  localparam int FL = 16;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       in_hsync, in_vsync, in_active;
  logic [5:0] in_rgb;
  logic       blank_req;
  logic [7:0] uo_out, uo_inv;
  logic [1:0] level, level_inv;
  logic       fade_busy, busy_inv, frame_tick, tick_inv;

  int n_cmp  = 0;
  int n_fail = 0;
  int fpos   = 0;
  int seen_ticks = 0;

  int         m_level, m_dir, m_cnt;
  bit         m_done, m_vs_prev;
  logic [8:0] m_q[$];
  logic [7:0] exp_uo, exp_uo_inv;
  logic       exp_tick, exp_busy;

  vga_fade_output_stage #(.PIPE_STAGES(P), .FADE_FRAMES(FF), .SYNC_INV(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_hsync(in_hsync), .in_vsync(in_vsync),
    .in_active(in_active), .in_rgb(in_rgb), .blank_req(blank_req), .uo_out(uo_out),
    .level(level), .fade_busy(fade_busy), .frame_tick(frame_tick));

  vga_fade_output_stage #(.PIPE_STAGES(P), .FADE_FRAMES(FF), .SYNC_INV(1'b1)) dut_inv (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_hsync(in_hsync), .in_vsync(in_vsync),
    .in_active(in_active), .in_rgb(in_rgb), .blank_req(blank_req), .uo_out(uo_inv),
    .level(level_inv), .fade_busy(busy_inv), .frame_tick(tick_inv));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  // Expected pins for one pipeline word at a given brightness
  function automatic logic [7:0] pack(input logic [8:0] w, input int lvl, input bit inv);
    int c[3];
    logic [1:0] r, g, b;
    c[0] = int'(w[5:4]);
    c[1] = int'(w[3:2]);
    c[2] = int'(w[1:0]);
    for (int i = 0; i < 3; i++) c[i] = w[6] ? ((c[i] < lvl) ? c[i] : lvl) : 0;
    r = 2'(c[0]);
    g = 2'(c[1]);
    b = 2'(c[2]);
    return {w[8] ^ inv, b[0], g[0], r[0], w[7] ^ inv, b[1], g[1], r[1]};
  endfunction

  task automatic model_reset();
    m_level = 0; m_dir = 1; m_done = 0; m_cnt = 0; m_vs_prev = 0;
    m_q.delete();
    for (int i = 0; i < P - 1; i++) m_q.push_back('0);
    exp_uo = '0; exp_uo_inv = '0; exp_tick = 1'b0; exp_busy = 1'b1;
  endtask

  // Advance one clock; the model sees the same inputs the DUT samples
  task automatic cyc();
    logic [8:0] w;
    int want;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      w = m_q.pop_front();
      m_q.push_back({in_hsync, in_vsync, in_active, in_rgb});
      exp_uo     = pack(w, m_level, 1'b0);
      exp_uo_inv = pack(w, m_level, 1'b1);
      exp_tick   = in_vsync && !m_vs_prev;
      m_vs_prev  = in_vsync;
      if (exp_tick && ena) begin
        want = blank_req ? -1 : 1;
        if (want != m_dir) begin
          m_dir = want; m_cnt = 0; m_done = 0;
        end else if (!m_done) begin
          m_cnt++;
          if (m_cnt == FF) begin
            m_cnt = 0;
            m_level = m_level + m_dir;
            if (m_level > 3) m_level = 3;
            if (m_level < 0) m_level = 0;
            if (m_level == ((m_dir > 0) ? 3 : 0)) m_done = 1;
          end
        end
      end
      exp_busy = !m_done;
    end
    #1;
  endtask

  task automatic drive_pixel(input bit rnd);
    in_vsync  = (fpos < 2);
    in_hsync  = rnd ? 1'($urandom_range(0, 1)) : ((fpos % 8) == 7);
    in_active = rnd ? 1'($urandom_range(0, 1)) : (fpos >= 4);
    if (rnd) in_rgb = 6'($urandom);
    fpos = (fpos + 1) % FL;
  endtask

  task automatic run_cycles(input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      drive_pixel(rnd);
      cyc();
      if (frame_tick === 1'b1) seen_ticks++;
      n_cmp++;
      if (uo_out !== exp_uo) begin
        n_fail++;
        $display("FAIL uo_out t=%0t got %h expected %h", $time, uo_out, exp_uo);
      end
      n_cmp++;
      if (uo_inv !== exp_uo_inv) begin
        n_fail++;
        $display("FAIL uo_out_inv t=%0t got %h expected %h", $time, uo_inv, exp_uo_inv);
      end
      n_cmp++;
      if ({level, fade_busy, frame_tick} !== {2'(m_level), exp_busy, exp_tick}) begin
        n_fail++;
        $display("FAIL status{level,busy,tick} t=%0t got %b expected %b", $time,
                 {level, fade_busy, frame_tick}, {2'(m_level), exp_busy, exp_tick});
      end
      n_cmp++;
      if ({level_inv, busy_inv, tick_inv} !== {2'(m_level), exp_busy, exp_tick}) begin
        n_fail++;
        $display("FAIL status_inv t=%0t got %b expected %b", $time,
                 {level_inv, busy_inv, tick_inv}, {2'(m_level), exp_busy, exp_tick});
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b1; blank_req = 1'b0;
    in_hsync = 1'b0; in_vsync = 1'b0; in_active = 1'b1; in_rgb = 6'b111111;
    model_reset();
    repeat (3) cyc();
    n_cmp++;
    if (uo_out !== 8'h00) begin n_fail++; $display("FAIL reset_uo got %h expected 00", uo_out); end
    n_cmp++;
    if ({level, frame_tick, fade_busy} !== 4'b0001) begin
      n_fail++; $display("FAIL reset_status got %b expected 0001", {level, frame_tick, fade_busy});
    end
    rst_n = 1'b1;
    fpos = 0;
  endtask

  task automatic test_fade_in();
    in_rgb = 6'b111111;
    run_cycles(FL, 1'b0);
    n_cmp++;
    if ((uo_out & 8'h77) !== 8'h00) begin n_fail++; $display("FAIL fade_in_black got %h expected 00", uo_out & 8'h77); end
    run_cycles(3 * FL, 1'b0);
    n_cmp++;
    if (level !== 2'd1) begin n_fail++; $display("FAIL fade_in_level1 got %0d expected 1", level); end
    n_cmp++;
    if ((uo_out & 8'h77) !== 8'h70) begin n_fail++; $display("FAIL fade_in_chan01 got %h expected 70", uo_out & 8'h77); end
    run_cycles(8 * FL, 1'b0);
    n_cmp++;
    if ({level, fade_busy} !== 3'b110) begin n_fail++; $display("FAIL fade_in_steady got %b expected 110", {level, fade_busy}); end
    n_cmp++;
    if ((uo_out & 8'h77) !== 8'h77) begin n_fail++; $display("FAIL fade_in_full got %h expected 77", uo_out & 8'h77); end
  endtask

  task automatic test_latency();
    in_vsync = 1'b0; in_active = 1'b1; in_hsync = 1'b0; in_rgb = 6'b000000;
    repeat (3) cyc();
    in_hsync = 1'b1; in_rgb = 6'b101010;
    cyc();
    n_cmp++;
    if (uo_out !== 8'h00) begin n_fail++; $display("FAIL latency_n1 got %h expected 00", uo_out); end
    cyc();
    n_cmp++;
    if (uo_out !== 8'h87) begin n_fail++; $display("FAIL latency_n2 got %h expected 87", uo_out); end
    n_cmp++;
    if (uo_inv !== 8'h0F) begin n_fail++; $display("FAIL latency_inv got %h expected 0f", uo_inv); end
  endtask

  task automatic test_blanking();
    in_active = 1'b0; in_rgb = 6'b101101; in_hsync = 1'b0; in_vsync = 1'b1;
    repeat (2) cyc();
    n_cmp++;
    if (uo_out !== 8'h08) begin n_fail++; $display("FAIL blank_vs got %h expected 08", uo_out); end
    in_hsync = 1'b1; in_vsync = 1'b0;
    repeat (2) cyc();
    n_cmp++;
    if (uo_out !== 8'h80) begin n_fail++; $display("FAIL blank_hs got %h expected 80", uo_out); end
    fpos = 2;
  endtask

  task automatic test_fade_reverse();
    fpos = 2;
    blank_req = 1'b1;
    run_cycles(FL, 1'b0);
    n_cmp++;
    if ({level, fade_busy} !== 3'b111) begin n_fail++; $display("FAIL rev_enter_out got %b expected 111", {level, fade_busy}); end
    run_cycles(4 * FL, 1'b0);
    n_cmp++;
    if (level !== 2'd2) begin n_fail++; $display("FAIL rev_level2 got %0d expected 2", level); end
    run_cycles(2 * FL, 1'b0);
    blank_req = 1'b0; run_cycles(4, 1'b0);
    blank_req = 1'b1; run_cycles(4, 1'b0);
    blank_req = 1'b0; run_cycles(8, 1'b0);
    n_cmp++;
    if ({level, fade_busy} !== 3'b101) begin n_fail++; $display("FAIL rev_reverse got %b expected 101", {level, fade_busy}); end
    run_cycles(3 * FL, 1'b0);
    n_cmp++;
    if (level !== 2'd2) begin n_fail++; $display("FAIL rev_cnt_cleared got %0d expected 2", level); end
    run_cycles(FL, 1'b0);
    n_cmp++;
    if ({level, fade_busy} !== 3'b110) begin n_fail++; $display("FAIL rev_back_steady got %b expected 110", {level, fade_busy}); end
  endtask

  task automatic test_freeze();
    fpos = 2;
    blank_req = 1'b1;
    run_cycles(5 * FL, 1'b0);
    n_cmp++;
    if (level !== 2'd2) begin n_fail++; $display("FAIL freeze_pre got %0d expected 2", level); end
    ena = 1'b0;
    seen_ticks = 0;
    run_cycles(10 * FL, 1'b0);
    n_cmp++;
    if (seen_ticks != 10) begin n_fail++; $display("FAIL freeze_ticks got %0d expected 10", seen_ticks); end
    n_cmp++;
    if ({level, fade_busy} !== 3'b101) begin n_fail++; $display("FAIL freeze_hold got %b expected 101", {level, fade_busy}); end
    ena = 1'b1;
    run_cycles(4 * FL, 1'b0);
    n_cmp++;
    if (level !== 2'd1) begin n_fail++; $display("FAIL freeze_resume got %0d expected 1", level); end
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 40; f++) begin
      blank_req = 1'($urandom_range(0, 1));
      ena = ($urandom_range(0, 4) != 0);
      run_cycles(FL / 2, 1'b1);
      if ($urandom_range(0, 3) == 0) blank_req = ~blank_req;
      run_cycles(FL / 2, 1'b1);
    end
    ena = 1'b1;
  endtask

  task automatic test_async_reset();
    blank_req = 1'b0; ena = 1'b1;
    run_cycles(14 * FL, 1'b0);
    n_cmp++;
    if ({level, fade_busy} !== 3'b110) begin n_fail++; $display("FAIL areset_pre got %b expected 110", {level, fade_busy}); end
    run_cycles(8, 1'b1);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if ({uo_out, uo_inv} !== 16'h0000) begin n_fail++; $display("FAIL areset_uo got %h expected 0000", {uo_out, uo_inv}); end
    n_cmp++;
    if ({level, fade_busy} !== 3'b001) begin n_fail++; $display("FAIL areset_status got %b expected 001", {level, fade_busy}); end
    repeat (2) cyc();
    rst_n = 1'b1;
    in_hsync = 1'b1; in_vsync = 1'b0; in_active = 1'b0;
    repeat (2) cyc();
    n_cmp++;
    if ({uo_inv[7], uo_inv[3], uo_out[7]} !== 3'b011) begin
      n_fail++; $display("FAIL areset_syncinv got %b expected 011", {uo_inv[7], uo_inv[3], uo_out[7]});
    end
    n_cmp++;
    if ({level, fade_busy} !== 3'b001) begin n_fail++; $display("FAIL areset_restart got %b expected 001", {level, fade_busy}); end
    fpos = 2;
    run_cycles(6 * FL, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; blank_req = 1'b0;
    in_hsync = 1'b0; in_vsync = 1'b0; in_active = 1'b0; in_rgb = '0;
    test_reset();
    test_fade_in();
    test_latency();
    test_blanking();
    test_fade_reverse();
    test_freeze();
    test_random_frames();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
